// File: rtl/control_sequencer_pkg.sv
// Shared constants for the bus control sequencer:
// opcodes, T-states and control-word bit positions.
package control_sequencer_pkg;

  localparam int OPW = 4;
  localparam int TW  = 3;

  typedef logic [OPW-1:0] op_t;
  typedef logic [TW-1:0]  ts_t;

  localparam op_t OP_NOP = 4'h0;
  localparam op_t OP_LDA = 4'h1;
  localparam op_t OP_ADD = 4'h2;
  localparam op_t OP_SUB = 4'h3;
  localparam op_t OP_STA = 4'h4;
  localparam op_t OP_LDI = 4'h5;
  localparam op_t OP_JMP = 4'h6;
  localparam op_t OP_JC  = 4'h7;
  localparam op_t OP_JZ  = 4'h8;
  localparam op_t OP_OUT = 4'hE;
  localparam op_t OP_HLT = 4'hF;

  localparam ts_t T0 = 3'd0;
  localparam ts_t T1 = 3'd1;
  localparam ts_t T2 = 3'd2;
  localparam ts_t T3 = 3'd3;
  localparam ts_t T4 = 3'd4;

  localparam int CW_PC_OE   = 0;
  localparam int CW_PC_IE   = 1;
  localparam int CW_PC_STEP = 2;
  localparam int CW_MAR_IE  = 3;
  localparam int CW_RAM_OE  = 4;
  localparam int CW_RAM_IE  = 5;
  localparam int CW_IR_IE   = 6;
  localparam int CW_IR_OE   = 7;
  localparam int CW_A_IE    = 8;
  localparam int CW_A_OE    = 9;
  localparam int CW_B_IE    = 10;
  localparam int CW_ALU_OE  = 11;
  localparam int CW_ALU_SUB = 12;
  localparam int CW_OUT_IE  = 13;
  localparam int CW_HLT     = 14;
  localparam int CWW        = 15;

  typedef logic [CWW-1:0] cw_t;

endpackage

// File: rtl/control_sequencer_rom.sv
// Combinational microcode: (tstate, opcode, flags) to
// control word plus end-of-instruction marker.
module control_rom
  import control_sequencer_pkg::*;
(
  input  ts_t  tstate,
  input  op_t  opcode,
  input  logic flag_c,
  input  logic flag_z,
  output cw_t  cw,
  output logic last
);

  logic has_exec;
  logic jump;

  always_comb begin
    unique case (opcode)
      OP_LDA, OP_ADD, OP_SUB, OP_STA,
      OP_LDI, OP_JMP, OP_JC, OP_JZ,
      OP_OUT, OP_HLT: has_exec = 1'b1;
      default:        has_exec = 1'b0;
    endcase
  end

  always_comb begin
    cw   = '0;
    last = 1'b0;
    jump = 1'b0;
    unique case (tstate)
      T0: begin
        cw[CW_PC_OE]  = 1'b1;
        cw[CW_MAR_IE] = 1'b1;
      end
      T1: begin
        cw[CW_RAM_OE]  = 1'b1;
        cw[CW_IR_IE]   = 1'b1;
        cw[CW_PC_STEP] = 1'b1;
        last = !has_exec;
      end
      T2: begin
        unique case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[CW_IR_OE]  = 1'b1;
            cw[CW_MAR_IE] = 1'b1;
          end
          OP_LDI: begin
            cw[CW_IR_OE] = 1'b1;
            cw[CW_A_IE]  = 1'b1;
            last = 1'b1;
          end
          OP_JMP, OP_JC, OP_JZ: begin
            jump = (opcode == OP_JMP)
                 | (opcode == OP_JC && flag_c)
                 | (opcode == OP_JZ && flag_z);
            cw[CW_IR_OE] = jump;
            cw[CW_PC_IE] = jump;
            last = 1'b1;
          end
          OP_OUT: begin
            cw[CW_A_OE]   = 1'b1;
            cw[CW_OUT_IE] = 1'b1;
            last = 1'b1;
          end
          OP_HLT: cw[CW_HLT] = 1'b1;
          default: last = 1'b1;
        endcase
      end
      T3: begin
        unique case (opcode)
          OP_LDA: begin
            cw[CW_RAM_OE] = 1'b1;
            cw[CW_A_IE]   = 1'b1;
            last = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_RAM_OE]  = 1'b1;
            cw[CW_B_IE]    = 1'b1;
            cw[CW_ALU_SUB] = (opcode == OP_SUB);
          end
          OP_STA: begin
            cw[CW_A_OE]   = 1'b1;
            cw[CW_RAM_IE] = 1'b1;
            last = 1'b1;
          end
          default: last = 1'b1;
        endcase
      end
      default: begin
        // T4 only exists for ADD/SUB; any other state wraps home.
        if (tstate == T4 &&
            (opcode == OP_ADD || opcode == OP_SUB)) begin
          cw[CW_ALU_OE]  = 1'b1;
          cw[CW_A_IE]    = 1'b1;
          cw[CW_ALU_SUB] = (opcode == OP_SUB);
        end
        last = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// T-state counter and halt register; strobes come from
// control_rom and are forced low while halted.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OPW = 4,
  parameter int TW  = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           flag_c,
  input  logic           flag_z,
  output logic           pc_oe,
  output logic           pc_ie,
  output logic           pc_step,
  output logic           mar_ie,
  output logic           ram_oe,
  output logic           ram_ie,
  output logic           ir_ie,
  output logic           ir_oe,
  output logic           a_ie,
  output logic           a_oe,
  output logic           b_ie,
  output logic           alu_oe,
  output logic           alu_sub,
  output logic           out_ie,
  output logic           halt,
  output logic [TW-1:0]  tstate
);

  cw_t         cw;
  cw_t         cw_g;
  logic        last;
  logic [TW-1:0] t_nxt;
  logic        halt_nxt;

  control_rom u_rom (
    .tstate (tstate),
    .opcode (opcode),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .cw     (cw),
    .last   (last)
  );

  always_comb begin
    t_nxt    = tstate;
    halt_nxt = halt;
    if (!halt) begin
      if (cw[CW_HLT])
        halt_nxt = 1'b1;
      else if (last)
        t_nxt = T0;
      else
        t_nxt = tstate + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tstate <= T0;
      halt   <= 1'b0;
    end else begin
      tstate <= t_nxt;
      halt   <= halt_nxt;
    end
  end

  assign cw_g = halt ? '0 : cw;

  assign pc_oe   = cw_g[CW_PC_OE];
  assign pc_ie   = cw_g[CW_PC_IE];
  assign pc_step = cw_g[CW_PC_STEP];
  assign mar_ie  = cw_g[CW_MAR_IE];
  assign ram_oe  = cw_g[CW_RAM_OE];
  assign ram_ie  = cw_g[CW_RAM_IE];
  assign ir_ie   = cw_g[CW_IR_IE];
  assign ir_oe   = cw_g[CW_IR_OE];
  assign a_ie    = cw_g[CW_A_IE];
  assign a_oe    = cw_g[CW_A_OE];
  assign b_ie    = cw_g[CW_B_IE];
  assign alu_oe  = cw_g[CW_ALU_OE];
  assign alu_sub = cw_g[CW_ALU_SUB];
  assign out_ie  = cw_g[CW_OUT_IE];

endmodule
